fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `fifo` instance between two packet-oriented requesters (A, B). It sits in front of the shared FIFO's write side and grants one client at a time with a registered grant state. A granted client holds ownership until its packet ends or a burst limit is reached. Data passes through combinationally: zero-latency ready/write, registered arbitration.

## Interface
- `DW`, 8: data width of each client and of the FIFO write port.
- `BURST_MAX`, 4: maximum consecutive beats per grant, ≥1.

Ports:
- `i_clk`  in  1  sole clock; all state updates on its rising edge.
- `i_resetn`  in  1  reset, synchronous, active-low.
- `i_ce`  in  1  clock enable; low freezes all state and suppresses all handshakes.
- `i_a_valid`  in  1  client A has a beat.
- `i_a_data`  in  DW  client A beat.
- `i_a_last`  in  1  A beat is the packet end.
- `o_a_ready`  out  1  A beat accepted this cycle when `i_a_valid` is also high.
- `i_b_valid`, `i_b_data`, `i_b_last`, `o_b_ready`: same as A, for client B.
- `i_full`  in  1  shared FIFO full.
- `o_wr`  out  1  FIFO write strobe.
- `o_wr_data`  out  DW  FIFO write data.
- `o_grant`  out  2  one-hot current owner: bit0 = A, bit1 = B; 00 = idle.

## Operation
- State machine: IDLE, OWN_A, OWN_B. Registers are `state`, `beat_cnt` (width $clog2(BURST_MAX+1)) and `rr_ptr`, where `rr_ptr` names the client with priority next.
- IDLE, with `i_ce` high:
  - Only A valid → OWN_A.
  - Only B valid → OWN_B.
  - Both valid → the client named by `rr_ptr`.
  - Neither valid → stay in IDLE.
  - No beats are accepted while in IDLE.
- OWN_X:
  - `o_x_ready` = `i_ce` & `i_resetn` & !`i_full`. The other client's ready is 0.
  - A beat is accepted when ready & valid. The accepted beat drives `o_wr`=1 and `o_wr_data`=`i_x_data` in the same cycle.
  - On each accepted beat, `beat_cnt` increments.
  - End of tenure: an accepted beat with `i_x_last`=1, or with `beat_cnt`==BURST_MAX-1.
  - At end of tenure, `rr_ptr` takes the other client and `beat_cnt` takes 0.
  - Next state at end of tenure: OWN_other if the other client is valid, else IDLE.
  - The handover A→B is direct, with no IDLE bubble.
- Burst cut mid-packet: the client resumes the remainder of its packet on its next grant. The arbiter does not track packet boundaries across tenures.
- `o_wr_data` is 0 whenever `o_wr`=0.
- `i_full` high while owning: no accept, state held, `beat_cnt` held.
- `i_ce` low: all registers held; ready and `o_wr` are forced 0; `o_grant` still reflects `state`.
- Reset, applied at any time including mid-packet:
  - In the same cycle: ready and `o_wr` are gated to 0.
  - At the next edge: `state`=IDLE, `beat_cnt`=0, `rr_ptr`=A.
  - The interrupted packet is not resumed specially.
- Reset values: `o_a_ready`=0, `o_b_ready`=0, `o_wr`=0, `o_wr_data`=0, `o_grant`=00.

## Timing
- Arbitration from IDLE: 1 cycle. Valid at edge n → grant visible after edge n → first accept in cycle n+1.
- Datapath latency: 0 cycles from an accepted beat to `o_wr`.
- Sustained throughput: 1 beat/cycle while not full.
- Owner switch: 0 idle cycles when the other client is waiting.
- `o_grant` is a registered decode of `state`.
- Ready depends combinationally on `i_full`, `i_ce` and `i_resetn` only, never on the client's own valid.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum (IDLE, OWN_A, OWN_B);
  - the client index constants (CLI_A=0, CLI_B=1);
  - a `BURST_CNT_W` helper function.
- One natural sub-module, `rr_pick2`: a combinational two-way round-robin choice taking the valids and `rr_ptr`, returning a one-hot pick. It is reused by the IDLE and end-of-tenure transitions.
- The FIFO itself stays outside the block. This block drives only its write side.

## Test plan
- Reset idle: hold `i_resetn`=0 for 3 cycles with both valid → `o_wr`=0, both readys 0, `o_grant`=00; after release, the first grant is A.
- Contention fairness:
  - Stimulus: both clients stream 2-beat packets continuously (A data 0x10, 0x11; B data 0x20, 0x21); BURST_MAX=4; `i_full`=0.
  - Required: FIFO write order is 0x10, 0x11, 0x20, 0x21, 0x10, 0x11, …; no idle cycles after the first grant.
- Burst cap:
  - Stimulus: A sends a 6-beat packet (0x01–0x06); B is valid throughout.
  - Required: A writes 0x01–0x04; B is then granted; A resumes with 0x05, 0x06 on its next tenure.
- Backpressure: `i_full`=1 for 3 cycles mid-packet → no writes, `beat_cnt` and grant unchanged; transfer resumes the cycle after `i_full` falls with no lost or duplicated beat.
- Clock enable: `i_ce`=0 for 2 cycles during OWN_B → no writes, `o_grant` stays 10, state resumes unchanged.
- Reset mid-packet: assert reset during beat 2 of a 3-beat A packet → that beat is not written; after release, the state is IDLE and `rr_ptr`=A.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and constants for the FIFO write-port arbiter.
//               - arb_state_t : arbiter ownership state (IDLE, OWN_A, OWN_B)
//               - CLI_A/CLI_B : client index into one-hot pick/grant vectors
//               - BURST_CNT_W : width of the per-tenure beat counter
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    localparam int CLI_A = 0;
    localparam int CLI_B = 1;

    // Counter must hold values 0..BURST_MAX; never narrower than one bit.
    function automatic int BURST_CNT_W(input int burst_max);
        return (burst_max < 1) ? 1 : $clog2(burst_max + 1);
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin choice.
//               i_valid  [1:0] : request per client (bit CLI_A, bit CLI_B)
//               i_rr_ptr       : client with priority when both request
//               o_pick   [1:0] : one-hot winner, 00 when nobody requests
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
    import fifo_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_rr_ptr,
    output logic [1:0] o_pick
);

    always_comb begin
        o_pick = 2'b00;
        case (i_valid)
            2'b01:   o_pick[CLI_A] = 1'b1;
            2'b10:   o_pick[CLI_B] = 1'b1;
            2'b11: begin
                if (i_rr_ptr) o_pick[CLI_B] = 1'b1;
                else          o_pick[CLI_A] = 1'b1;
            end
            default: o_pick = 2'b00;
        endcase
    end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing one FIFO write port between two
//               packet clients A and B. Grant is registered; ready, write
//               strobe and write data are combinational pass-through.
//   i_clk, i_resetn (sync, active-low), i_ce (clock enable)
//   i_x_valid/i_x_data/i_x_last/o_x_ready : client x (a, b) beat handshake
//   i_full                                : shared FIFO full
//   o_wr/o_wr_data                        : FIFO write side
//   o_grant                               : one-hot owner (bit0 A, bit1 B)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int BURST_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic          i_ce,
    input  logic          i_a_valid,
    input  logic [DW-1:0] i_a_data,
    input  logic          i_a_last,
    output logic          o_a_ready,
    input  logic          i_b_valid,
    input  logic [DW-1:0] i_b_data,
    input  logic          i_b_last,
    output logic          o_b_ready,
    input  logic          i_full,
    output logic          o_wr,
    output logic [DW-1:0] o_wr_data,
    output logic [1:0]    o_grant
);

    localparam int                 c_CNT_W    = BURST_CNT_W(BURST_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BURST_MAX - 1);

    arb_state_t         r_state,    w_state_nxt;
    logic [c_CNT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic               r_rr_ptr,   w_rr_ptr_nxt;
    logic [1:0]         r_grant,    w_grant_nxt;

    logic       w_hs_ok;
    logic       w_acc_a;
    logic       w_acc_b;
    logic       w_end;
    logic [1:0] w_cand;
    logic [1:0] w_pick;

    // Ready is a function of enable/reset/full and ownership only, never of
    // the client's own valid, so clients may present valid after ready.
    assign w_hs_ok   = i_ce & i_resetn & ~i_full;
    assign o_a_ready = w_hs_ok & (r_state == OWN_A);
    assign o_b_ready = w_hs_ok & (r_state == OWN_B);
    assign w_acc_a   = o_a_ready & i_a_valid;
    assign w_acc_b   = o_b_ready & i_b_valid;

    // Tenure closes on the packet end or on the last beat of the burst cap.
    assign w_end = (w_acc_a & (i_a_last | (r_beat_cnt == c_CNT_LAST)))
                 | (w_acc_b & (i_b_last | (r_beat_cnt == c_CNT_LAST)));

    assign o_wr      = w_acc_a | w_acc_b;
    assign o_wr_data = w_acc_a ? i_a_data : (w_acc_b ? i_b_data : '0);
    assign o_grant   = r_grant;

    // In IDLE both clients compete; at end of tenure only the other client
    // is a candidate, so the same picker yields the direct handover.
    always_comb begin
        w_cand = 2'b00;
        case (r_state)
            IDLE:    w_cand = {i_b_valid, i_a_valid};
            OWN_A:   w_cand = {i_b_valid, 1'b0};
            OWN_B:   w_cand = {1'b0, i_a_valid};
            default: w_cand = 2'b00;
        endcase
    end

    rr_pick2 u_pick (
        .i_valid  (w_cand),
        .i_rr_ptr (r_rr_ptr),
        .o_pick   (w_pick)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_beat_cnt_nxt = r_beat_cnt;
        w_rr_ptr_nxt   = r_rr_ptr;
        if (i_ce) begin
            case (r_state)
                IDLE: begin
                    if (w_pick[CLI_A])      w_state_nxt = OWN_A;
                    else if (w_pick[CLI_B]) w_state_nxt = OWN_B;
                end
                OWN_A, OWN_B: begin
                    if (w_acc_a | w_acc_b) begin
                        if (w_end) begin
                            w_beat_cnt_nxt = '0;
                            w_rr_ptr_nxt   = (r_state == OWN_A) ? 1'b1 : 1'b0;
                            if (w_pick[CLI_B])      w_state_nxt = OWN_B;
                            else if (w_pick[CLI_A]) w_state_nxt = OWN_A;
                            else                    w_state_nxt = IDLE;
                        end else begin
                            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
        w_grant_nxt = 2'b00;
        if (w_state_nxt == OWN_A) w_grant_nxt[CLI_A] = 1'b1;
        if (w_state_nxt == OWN_B) w_grant_nxt[CLI_B] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_rr_ptr   <= 1'b0;
            r_grant    <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant    <= w_grant_nxt;
        end
    end

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter. A per-cycle vector
//               table walks reset, grant, full, clock-enable and reset
//               mid-packet; streamed client sequences cover contention
//               fairness, the burst cap and backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int DW        = 8;
    localparam int BURST_MAX = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ce;
    logic          a_valid, a_last, b_valid, b_last, full;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready, wr;
    logic [DW-1:0] wr_data;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DW(DW), .BURST_MAX(BURST_MAX)) dut (
        .i_clk     (clk),
        .i_resetn  (resetn),
        .i_ce      (ce),
        .i_a_valid (a_valid),
        .i_a_data  (a_data),
        .i_a_last  (a_last),
        .o_a_ready (a_ready),
        .i_b_valid (b_valid),
        .i_b_data  (b_data),
        .i_b_last  (b_last),
        .o_b_ready (b_ready),
        .i_full    (full),
        .o_wr      (wr),
        .o_wr_data (wr_data),
        .o_grant   (grant)
    );

    typedef struct packed {
        logic       rn, ce, av;
        logic [7:0] ad;
        logic       al, bv;
        logic [7:0] bd;
        logic       bl, full;
        logic       ar, br, wr;
        logic [7:0] wd;
        logic [1:0] gr;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [0:NVEC-1];

    function automatic vec_t mk(logic rn, logic c, logic av, logic [7:0] ad,
                                logic al, logic bv, logic [7:0] bd, logic bl,
                                logic fl, logic ar, logic br, logic w,
                                logic [7:0] wd, logic [1:0] gr);
        vec_t v;
        v.rn = rn; v.ce = c; v.av = av; v.ad = ad; v.al = al;
        v.bv = bv; v.bd = bd; v.bl = bl; v.full = fl;
        v.ar = ar; v.br = br; v.wr = w; v.wd = wd; v.gr = gr;
        return v;
    endfunction

    // Expected write per cycle of a streamed sequence: data, or -1 for none.
    int exp_w [0:15];

    task automatic drive_idle();
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        full = 1'b0; ce = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive_idle();
        resetn = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    // Clients behave as packet sources: A sends a_pkts packets (0 = endless)
    // of a_len beats starting at a_base; B streams b_len-beat packets
    // (b_len = 0 keeps B silent). i_full is high for cycles full_lo..full_hi.
    task automatic run_stream(input int a_len, input int a_base, input int a_pkts,
                              input int b_len, input int b_base,
                              input int full_lo, input int full_hi,
                              input int ncyc, input string tag);
        int a_idx = 0;
        int a_done = 0;
        int b_idx = 0;
        int act;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            a_valid = (a_pkts == 0) || (a_done < a_pkts);
            a_data  = a_valid ? DW'(a_base + a_idx) : '0;
            a_last  = a_valid && (a_idx == a_len - 1);
            b_valid = (b_len != 0);
            b_data  = DW'(b_base + b_idx);
            b_last  = (b_idx == b_len - 1);
            full    = (c >= full_lo) && (c <= full_hi);
            @(negedge clk);
            act = wr ? int'(wr_data) : ((wr_data == '0) ? -1 : -2);
            n_checks++;
            if (act != exp_w[c]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: write got %0d, want %0d", tag, c, act, exp_w[c]);
            end
            if (a_ready && a_valid) begin
                if (a_idx == a_len - 1) begin a_idx = 0; a_done++; end
                else a_idx++;
            end
            if (b_ready && b_valid) begin
                if (b_idx == b_len - 1) b_idx = 0;
                else b_idx++;
            end
        end
    endtask

    initial begin
        //                rn ce av ad     al bv bd     bl fl  ar br wr wd     gr
        tbl[0]  = mk(0, 1, 1, 8'hAA, 0, 1, 8'hBB, 0, 0,  0, 0, 0, 8'h00, 2'b00);
        tbl[1]  = mk(0, 1, 1, 8'hAA, 0, 1, 8'hBB, 0, 0,  0, 0, 0, 8'h00, 2'b00);
        tbl[2]  = mk(0, 1, 1, 8'hAA, 0, 1, 8'hBB, 0, 0,  0, 0, 0, 8'h00, 2'b00);
        tbl[3]  = mk(1, 1, 1, 8'hAA, 0, 1, 8'hBB, 0, 0,  0, 0, 0, 8'h00, 2'b00);
        tbl[4]  = mk(1, 1, 1, 8'h31, 0, 1, 8'h41, 0, 0,  1, 0, 1, 8'h31, 2'b01);
        tbl[5]  = mk(1, 1, 1, 8'h32, 1, 1, 8'h41, 0, 0,  1, 0, 1, 8'h32, 2'b01);
        tbl[6]  = mk(1, 1, 1, 8'h33, 1, 1, 8'h41, 0, 1,  0, 0, 0, 8'h00, 2'b10);
        tbl[7]  = mk(1, 0, 1, 8'h33, 1, 1, 8'h41, 0, 0,  0, 0, 0, 8'h00, 2'b10);
        tbl[8]  = mk(1, 0, 1, 8'h33, 1, 1, 8'h41, 0, 0,  0, 0, 0, 8'h00, 2'b10);
        tbl[9]  = mk(1, 1, 1, 8'h33, 1, 1, 8'h41, 1, 0,  0, 1, 1, 8'h41, 2'b10);
        tbl[10] = mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 2'b01);
        tbl[11] = mk(1, 1, 1, 8'h50, 1, 0, 8'h00, 0, 0,  1, 0, 1, 8'h50, 2'b01);
        tbl[12] = mk(1, 1, 1, 8'h60, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 2'b00);
        tbl[13] = mk(1, 1, 1, 8'h60, 0, 0, 8'h00, 0, 0,  1, 0, 1, 8'h60, 2'b01);
        tbl[14] = mk(0, 1, 1, 8'h61, 0, 1, 8'h70, 0, 0,  0, 0, 0, 8'h00, 2'b01);
        tbl[15] = mk(1, 1, 1, 8'h61, 0, 1, 8'h70, 1, 0,  0, 0, 0, 8'h00, 2'b00);
        tbl[16] = mk(1, 1, 1, 8'h61, 0, 1, 8'h70, 1, 0,  1, 0, 1, 8'h61, 2'b01);
        tbl[17] = mk(1, 1, 1, 8'h62, 0, 1, 8'h70, 1, 0,  1, 0, 1, 8'h62, 2'b01);
        tbl[18] = mk(1, 1, 1, 8'h63, 0, 1, 8'h70, 1, 0,  1, 0, 1, 8'h63, 2'b01);
        tbl[19] = mk(1, 1, 1, 8'h64, 0, 1, 8'h70, 1, 0,  1, 0, 1, 8'h64, 2'b01);
        tbl[20] = mk(1, 1, 1, 8'h65, 1, 1, 8'h70, 1, 0,  0, 1, 1, 8'h70, 2'b10);
        tbl[21] = mk(1, 1, 1, 8'h65, 1, 0, 8'h00, 0, 0,  1, 0, 1, 8'h65, 2'b01);
        tbl[22] = mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  0, 0, 0, 8'h00, 2'b00);

        drive_idle();
        resetn = 1'b0;
        @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1;
            resetn  = tbl[i].rn;   ce      = tbl[i].ce;
            a_valid = tbl[i].av;   a_data  = tbl[i].ad;  a_last = tbl[i].al;
            b_valid = tbl[i].bv;   b_data  = tbl[i].bd;  b_last = tbl[i].bl;
            full    = tbl[i].full;
            @(negedge clk);
            n_checks++;
            if ({a_ready, b_ready, wr, wr_data, grant} !=
                {tbl[i].ar, tbl[i].br, tbl[i].wr, tbl[i].wd, tbl[i].gr}) begin
                n_fail++;
                $display("FAIL vec%0d: got ar=%0b br=%0b wr=%0b wd=%02h gr=%02b, want ar=%0b br=%0b wr=%0b wd=%02h gr=%02b",
                         i, a_ready, b_ready, wr, wr_data, grant,
                         tbl[i].ar, tbl[i].br, tbl[i].wr, tbl[i].wd, tbl[i].gr);
            end
        end

        // Contention: alternating 2-beat packets, no idle after first grant.
        do_reset();
        exp_w[0] = -1;
        for (int c = 1; c < 13; c++) begin
            case ((c - 1) % 4)
                0:       exp_w[c] = 'h10;
                1:       exp_w[c] = 'h11;
                2:       exp_w[c] = 'h20;
                default: exp_w[c] = 'h21;
            endcase
        end
        run_stream(2, 'h10, 0, 2, 'h20, -1, -1, 13, "fairness");

        // Burst cap: 6-beat A packet split 4 + 2 around a B packet.
        do_reset();
        exp_w[0] = -1;   exp_w[1] = 'h01; exp_w[2] = 'h02; exp_w[3] = 'h03;
        exp_w[4] = 'h04; exp_w[5] = 'h20; exp_w[6] = 'h21; exp_w[7] = 'h05;
        exp_w[8] = 'h06; exp_w[9] = 'h20; exp_w[10] = 'h21;
        run_stream(6, 'h01, 1, 2, 'h20, -1, -1, 11, "burst_cap");

        // Backpressure: full for 3 cycles mid-packet; cap position proves
        // the beat counter held while full.
        do_reset();
        exp_w[0] = -1;   exp_w[1] = 'h01; exp_w[2] = 'h02; exp_w[3] = -1;
        exp_w[4] = -1;   exp_w[5] = -1;   exp_w[6] = 'h03; exp_w[7] = 'h04;
        exp_w[8] = -1;   exp_w[9] = 'h05; exp_w[10] = 'h06;
        run_stream(6, 'h01, 1, 0, 'h00, 3, 5, 11, "backpressure");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
